cc_pos_monitor: RTL
===================

// Module: cc_pos_monitor
// PURPOSE
//  Multi-channel, registered, debounced position comparator for the game datapath.
//  Each channel's position bus is compared against zero or a shared reference, using a selectable mode.
//  A match must be stable for STABLE_CYCLES before the active-low T0 flag changes.
//  Each newly asserted match gives a one-cycle event pulse and sets a sticky flag, which the control FSM clears.
// PARAMETERS
//  DATAWIDTH      3  width of each channel position and of the reference (>=1)
//  CHANNELS       4  number of monitored channels (1..16)
//  STABLE_CYCLES  2  consecutive sampled cycles a changed compare result must persist (>=1)
//  CNTWIDTH       localparam = clog2(STABLE_CYCLES)+1, debounce counter width
// PORTS
//  CC_POSMONITOR_CLOCK_50      in   1                    system clock, rising edge
//  CC_POSMONITOR_RESET_InHigh  in   1                    asynchronous reset, active high
//  CC_POSMONITOR_enable_InHigh in   1                    1 = sample and debounce; 0 = freeze
//  CC_POSMONITOR_clear_InHigh  in   1                    clear all sticky flags
//  CC_POSMONITOR_mode_InBUS    in   2                    00 zero, 01 eq ref, 10 gt ref, 11 lt ref
//  CC_POSMONITOR_ref_InBUS     in   DATAWIDTH            shared reference value
//  CC_POSMONITOR_data_InBUS    in   CHANNELS*DATAWIDTH   ch i = bits [i*DATAWIDTH +: DATAWIDTH]
//  CC_POSMONITOR_T0_OutLow     out  CHANNELS             debounced flag, 0 = match stable
//  CC_POSMONITOR_event_OutBUS  out  CHANNELS             1-cycle pulse when ch enters match
//  CC_POSMONITOR_sticky_OutBUS out  CHANNELS             latched events until clear
//  CC_POSMONITOR_any_OutHigh   out  1                    registered OR of sticky
// BEHAVIOUR
//  - Reset (async, immediate): sample regs=0, counters=0, state=no-match (T0=all 1), event=0, sticky=0, any=0.
//  - Stage 1 (enable=1): register data, ref and mode together. Enable=0: hold them.
//  - Raw match (combinational from stage 1, unsigned compare):
//    00 d==0; 01 d==ref; 10 d>ref; 11 d<ref.
//  - Per channel, each edge with enable=1:
//    - raw==state: cnt<=0.
//    - raw!=state and cnt==STABLE_CYCLES-1: state<=raw, cnt<=0.
//    - otherwise: cnt<=cnt+1.
//  - Any raw glitch back to state resets cnt, so no partial credit carries over.
//  - Latency: input change before edge k -> T0 changes at edge k+STABLE_CYCLES (k samples it).
//  - event[i]<=1 only on the edge where state goes no-match->match; 0 on every other edge.
//    Enable=0 forces event=0 and freezes cnt/state.
//  - sticky[i] <= (sticky[i] & ~clear) | event_next[i]. A set in the same cycle as clear wins.
//    Clear works regardless of enable.
//  - any <= |sticky_next, registered and aligned with sticky.
//  - A mode/ref change mid-debounce is allowed: debounce continues against the new raw result, with no special reset.
//  - The sample reg resets to 0. With mode 00 every channel therefore reaches match STABLE_CYCLES edges after reset release, firing event.
//  - Reset asserted mid-operation aborts all counts; outputs return to reset values within the same cycle.
// STRUCTURE
//  - Package cc_posmonitor_pkg: MODE_ZERO=2'b00, MODE_EQ=2'b01, MODE_GT=2'b10, MODE_LT=2'b11.
//    Also a constant function clog2 and the mode typedef (2-bit).
//  - Sub-module cc_pos_debounce_ch: one channel's raw compare, counter, state, event and sticky.
//    Instantiated CHANNELS times via generate.
//  - Top level keeps the stage-1 regs and the any_OutHigh reduction.
// TESTING (DATAWIDTH=3, CHANNELS=4, STABLE_CYCLES=2)
//  1 Reset release, mode 00, data all 0 -> T0=4'b1111 for 1 edge, 4'b0000 after edge 2.
//    Same edge: event=4'b1111 for 1 cycle, sticky=4'b1111, any=1.
//  2 Mode 00, ch1 idle at 3'd5, one-cycle glitch to 3'd0 -> T0[1] stays 1, event[1]=0, sticky[1] unchanged.
//  3 Mode 00, clear sticky, ch2 5->0 before edge k -> T0[2]=0 after edge k+2.
//    event[2]=1 for exactly 1 cycle; sticky[2]=1; any=1.
//  4 ref=3'd6: mode 01 ch0=6 -> match; mode 10 ch0=7 match, ch0=6 no match.
//    Mode 11 ch3=0 match (unsigned). T0 follows after 2 stable edges.
//  5 clear=1 on the event edge -> sticky bit set. Next cycle clear=1, no event -> sticky=0, any=0 one edge later.
//  6 Enable=0 while cnt=1 -> T0/cnt frozen, no event. Then assert reset mid-debounce -> all outputs at reset values immediately.

Source files
------------

// File: rtl/cc_posmonitor_pkg.sv
// Shared definitions for the position monitor: compare modes and a width helper.
package cc_posmonitor_pkg;

  typedef enum logic [1:0] {
    MODE_ZERO = 2'b00,
    MODE_EQ   = 2'b01,
    MODE_GT   = 2'b10,
    MODE_LT   = 2'b11
  } posMode_t;

  // Constant ceiling log2; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/cc_pos_debounce_ch.sv
// One channel: raw compare against the staged reference, debounce counter,
// stable match state, entry event pulse and sticky flag.
module cc_pos_debounce_ch
  import cc_posmonitor_pkg::*;
#(
  parameter int DATAWIDTH     = 3,
  parameter int STABLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 clear,
  input  posMode_t             mode,
  input  logic [DATAWIDTH-1:0] refVal,
  input  logic [DATAWIDTH-1:0] data,
  output logic                 matchState,
  output logic                 eventPulse,
  output logic                 sticky,
  output logic                 stickyNext
);

  localparam int CNTWIDTH = clog2(STABLE_CYCLES) + 1;
  localparam logic [CNTWIDTH-1:0] LAST_CNT = CNTWIDTH'(STABLE_CYCLES - 1);

  logic                raw;
  logic [CNTWIDTH-1:0] cntReg, cntNext;
  logic                stateReg, stateNext;
  logic                eventReg, eventNext;
  logic                stickyReg;

  always_comb begin
    raw = 1'b0;
    case (mode)
      MODE_ZERO: raw = (data == '0);
      MODE_EQ:   raw = (data == refVal);
      MODE_GT:   raw = (data > refVal);
      MODE_LT:   raw = (data < refVal);
      default:   raw = 1'b0;
    endcase
  end

  // Any sample agreeing with the current state throws away accumulated credit.
  always_comb begin
    cntNext   = cntReg;
    stateNext = stateReg;
    eventNext = 1'b0;
    if (enable) begin
      if (raw == stateReg) begin
        cntNext = '0;
      end else if (cntReg == LAST_CNT) begin
        stateNext = raw;
        cntNext   = '0;
        eventNext = raw;
      end else begin
        cntNext = cntReg + 1'b1;
      end
    end
    stickyNext = (stickyReg & ~clear) | eventNext;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cntReg    <= '0;
      stateReg  <= 1'b0;
      eventReg  <= 1'b0;
      stickyReg <= 1'b0;
    end else begin
      cntReg    <= cntNext;
      stateReg  <= stateNext;
      eventReg  <= eventNext;
      stickyReg <= stickyNext;
    end
  end

  assign matchState = stateReg;
  assign eventPulse = eventReg;
  assign sticky     = stickyReg;

endmodule

// File: rtl/cc_pos_monitor.sv
// Multi-channel debounced position comparator: stage-1 input registers,
// per-channel debounce instances and the registered any-sticky summary.
module cc_pos_monitor
  import cc_posmonitor_pkg::*;
#(
  parameter int DATAWIDTH     = 3,
  parameter int CHANNELS      = 4,
  parameter int STABLE_CYCLES = 2
) (
  input  logic                          CC_POSMONITOR_CLOCK_50,
  input  logic                          CC_POSMONITOR_RESET_InHigh,
  input  logic                          CC_POSMONITOR_enable_InHigh,
  input  logic                          CC_POSMONITOR_clear_InHigh,
  input  logic [1:0]                    CC_POSMONITOR_mode_InBUS,
  input  logic [DATAWIDTH-1:0]          CC_POSMONITOR_ref_InBUS,
  input  logic [CHANNELS*DATAWIDTH-1:0] CC_POSMONITOR_data_InBUS,
  output logic [CHANNELS-1:0]           CC_POSMONITOR_T0_OutLow,
  output logic [CHANNELS-1:0]           CC_POSMONITOR_event_OutBUS,
  output logic [CHANNELS-1:0]           CC_POSMONITOR_sticky_OutBUS,
  output logic                          CC_POSMONITOR_any_OutHigh
);

  logic                          clk;
  logic                          rst;
  logic [CHANNELS*DATAWIDTH-1:0] dataReg;
  logic [DATAWIDTH-1:0]          refReg;
  posMode_t                      modeReg;
  logic [CHANNELS-1:0]           stateVec;
  logic [CHANNELS-1:0]           stickyNextVec;
  logic                          anyReg;

  assign clk = CC_POSMONITOR_CLOCK_50;
  assign rst = CC_POSMONITOR_RESET_InHigh;

  // Data, reference and mode are captured together so a compare never mixes stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dataReg <= '0;
      refReg  <= '0;
      modeReg <= MODE_ZERO;
    end else if (CC_POSMONITOR_enable_InHigh) begin
      dataReg <= CC_POSMONITOR_data_InBUS;
      refReg  <= CC_POSMONITOR_ref_InBUS;
      modeReg <= posMode_t'(CC_POSMONITOR_mode_InBUS);
    end
  end

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : gCh
      cc_pos_debounce_ch #(
        .DATAWIDTH    (DATAWIDTH),
        .STABLE_CYCLES(STABLE_CYCLES)
      ) uCh (
        .clk       (clk),
        .rst       (rst),
        .enable    (CC_POSMONITOR_enable_InHigh),
        .clear     (CC_POSMONITOR_clear_InHigh),
        .mode      (modeReg),
        .refVal    (refReg),
        .data      (dataReg[gi*DATAWIDTH +: DATAWIDTH]),
        .matchState(stateVec[gi]),
        .eventPulse(CC_POSMONITOR_event_OutBUS[gi]),
        .sticky    (CC_POSMONITOR_sticky_OutBUS[gi]),
        .stickyNext(stickyNextVec[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) anyReg <= 1'b0;
    else     anyReg <= |stickyNextVec;
  end

  assign CC_POSMONITOR_T0_OutLow   = ~stateVec;
  assign CC_POSMONITOR_any_OutHigh = anyReg;

endmodule
